// File: rtl/aer_pkg.sv
// Shared constants and event type for the AER input path.
// Default field widths and the bit positions of the fields inside a packed AER word.
package aer_pkg;

   localparam int AER_CH_W  = 4;
   localparam int AER_TS_W  = 20;
   localparam int AER_EXT_W = 8;

   // AER word layout: {channel, raw_timestamp}
   localparam int AER_TS_LSB = 0;
   localparam int AER_TS_MSB = AER_TS_W - 1;
   localparam int AER_CH_LSB = AER_TS_W;
   localparam int AER_CH_MSB = AER_TS_W + AER_CH_W - 1;

   typedef struct packed {
      logic [AER_CH_W-1:0]           channel;
      logic [AER_EXT_W+AER_TS_W-1:0] ext_timestamp;
   } aer_event_t;

endpackage

// File: rtl/aer_sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is always visible on pop_data.
// A push while full and a pop while empty are both ignored.
module aer_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_reg == (AW+1)'(DEPTH));
   assign empty    = (count_reg == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   // Shallow storage, so the head is read combinationally to give show-ahead.
   assign pop_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/aer_event_decoder.sv
// AER input decoder: masks channels, extends timestamps with a wrap counter,
// buffers accepted events and counts the ones discarded by the channel mask.
module aer_event_decoder
   import aer_pkg::*;
#(
   parameter int CH_W  = AER_CH_W,
   parameter int TS_W  = AER_TS_W,
   parameter int EXT_W = AER_EXT_W,
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CH_W+TS_W-1:0]  in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2**CH_W-1:0]    ch_mask,
   input  logic                  clear_stats,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH_W-1:0]       out_channel,
   output logic [EXT_W+TS_W-1:0] out_timestamp,
   output logic [15:0]           drop_count,
   output logic                  wrap_seen
);

   localparam int NCH = 2**CH_W;
   localparam int EW  = CH_W + EXT_W + TS_W;

   logic [CH_W-1:0]  in_channel;
   logic [TS_W-1:0]  in_ts;
   logic [NCH-1:0]   ch_hit;
   logic             ch_enabled;
   logic             accept;
   logic             is_wrap;
   logic             drop;
   logic [TS_W-1:0]  last_ts_reg;
   logic [EXT_W-1:0] wrap_cnt_reg;
   logic [EXT_W-1:0] wrap_cnt_next;
   logic [15:0]      drop_count_reg;
   logic [15:0]      drop_count_next;
   logic             wrap_seen_reg;
   logic             wrap_seen_next;
   logic             fifo_push;
   logic             fifo_pop;
   logic [EW-1:0]    fifo_wdata;
   logic [EW-1:0]    fifo_head;
   logic             fifo_full;
   logic             fifo_empty;

   assign in_channel = in_data[CH_W+TS_W-1:TS_W];
   assign in_ts      = in_data[TS_W-1:0];

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch_decode
         assign ch_hit[gi] = (in_channel == CH_W'(gi));
      end
   endgenerate

   assign ch_enabled = |(ch_hit & ch_mask);
   assign accept     = in_valid && in_ready;
   assign is_wrap    = (in_ts < last_ts_reg);
   assign drop       = accept && !ch_enabled;
   assign fifo_push  = accept && ch_enabled;
   // The pushed event already carries the incremented count when this word wraps.
   assign wrap_cnt_next = is_wrap ? wrap_cnt_reg + EXT_W'(1) : wrap_cnt_reg;
   assign fifo_wdata    = {in_channel, wrap_cnt_next, in_ts};

   always_comb begin
      drop_count_next = drop_count_reg;
      wrap_seen_next  = wrap_seen_reg;
      if (clear_stats) begin
         drop_count_next = '0;
         wrap_seen_next  = 1'b0;
      end else begin
         if (drop && (drop_count_reg != 16'hFFFF)) begin
            drop_count_next = drop_count_reg + 16'd1;
         end
         if (accept && is_wrap) begin
            wrap_seen_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_ts_reg    <= '0;
         wrap_cnt_reg   <= '0;
         drop_count_reg <= '0;
         wrap_seen_reg  <= 1'b0;
      end else begin
         if (accept) begin
            last_ts_reg  <= in_ts;
            wrap_cnt_reg <= wrap_cnt_next;
         end
         drop_count_reg <= drop_count_next;
         wrap_seen_reg  <= wrap_seen_next;
      end
   end

   aer_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Handshakes are forced idle while rst is held, not just after the reset edge.
   assign in_ready      = !rst && !fifo_full;
   assign out_valid     = !rst && !fifo_empty;
   assign fifo_pop      = out_valid && out_ready;
   assign out_channel   = out_valid ? fifo_head[EW-1:EXT_W+TS_W] : '0;
   assign out_timestamp = out_valid ? fifo_head[EXT_W+TS_W-1:0] : '0;
   assign drop_count    = drop_count_reg;
   assign wrap_seen     = wrap_seen_reg;

endmodule

// File: tb/tb_aer_event_decoder.sv
// Directed bench for aer_event_decoder: reset, wrap, masking, backpressure,
// concurrent push/pop and mid-stream reset, with hand-computed expectations.
module tb_aer_event_decoder;
   import aer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] ch_mask;
   logic        clear_stats;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_channel;
   logic [27:0] out_timestamp;
   logic [15:0] drop_count;
   logic        wrap_seen;

   int checks   = 0;
   int failures = 0;

   aer_event_decoder #(
      .CH_W  (AER_CH_W),
      .TS_W  (AER_TS_W),
      .EXT_W (AER_EXT_W),
      .DEPTH (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .ch_mask       (ch_mask),
      .clear_stats   (clear_stats),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_channel   (out_channel),
      .out_timestamp (out_timestamp),
      .drop_count    (drop_count),
      .wrap_seen     (wrap_seen)
   );

   always #5 clk = ~clk;

   // Drive one word and hold it until accepted (bounded wait).
   task automatic push_word(input logic [23:0] w);
      int n;
      in_data  = w;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL push_timeout word=%h in_ready=%b required 1", w, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      $display("push word=%h drop_count=%0d wrap_seen=%b", w, drop_count, wrap_seen);
   endtask

   task automatic do_pop();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_channel !== 4'd0 || out_timestamp !== 28'd0) begin
         failures++;
         $display("FAIL reset_hold in_ready=%b out_valid=%b ch=%h ts=%h required 0 0 0 0",
                  in_ready, out_valid, out_channel, out_timestamp);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || drop_count !== 16'd0 || wrap_seen !== 1'b0) begin
         failures++;
         $display("FAIL reset_release in_ready=%b out_valid=%b drop=%h wrap_seen=%b required 1 0 0 0",
                  in_ready, out_valid, drop_count, wrap_seen);
      end
      $display("reset done in_ready=%b out_valid=%b", in_ready, out_valid);
   endtask

   task automatic test_single();
      push_word(24'h3_00010);
      checks++;
      if (out_valid !== 1'b1 || out_channel !== 4'd3 || out_timestamp !== 28'h00_00010) begin
         failures++;
         $display("FAIL single_event valid=%b ch=%h ts=%h required 1 3 0000010",
                  out_valid, out_channel, out_timestamp);
      end
      do_pop();
      checks++;
      if (out_valid !== 1'b0 || out_channel !== 4'd0 || out_timestamp !== 28'd0) begin
         failures++;
         $display("FAIL single_empty valid=%b ch=%h ts=%h required 0 0 0",
                  out_valid, out_channel, out_timestamp);
      end
   endtask

   task automatic test_wrap();
      push_word(24'h1_FFFF0);
      checks++;
      if (wrap_seen !== 1'b0 || out_timestamp !== 28'h00_FFFF0) begin
         failures++;
         $display("FAIL wrap_none wrap_seen=%b ts=%h required 0 00FFFF0", wrap_seen, out_timestamp);
      end
      push_word(24'h1_00005);
      checks++;
      if (wrap_seen !== 1'b1) begin
         failures++;
         $display("FAIL wrap_seen got=%b required 1", wrap_seen);
      end
      push_word(24'h2_00005);
      do_pop();
      checks++;
      if (out_channel !== 4'd1 || out_timestamp !== 28'h01_00005) begin
         failures++;
         $display("FAIL wrap_event ch=%h ts=%h required 1 0100005", out_channel, out_timestamp);
      end
      do_pop();
      checks++;
      if (out_channel !== 4'd2 || out_timestamp !== 28'h01_00005) begin
         failures++;
         $display("FAIL wrap_equal ch=%h ts=%h required 2 0100005", out_channel, out_timestamp);
      end
      do_pop();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL wrap_drain valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_mask();
      ch_mask = 16'hFFFB;
      push_word(24'h2_00100);
      push_word(24'h2_00101);
      push_word(24'h2_00102);
      push_word(24'h5_00103);
      checks++;
      if (drop_count !== 16'd3) begin
         failures++;
         $display("FAIL mask_drop_count got=%0d required 3", drop_count);
      end
      checks++;
      if (out_valid !== 1'b1 || out_channel !== 4'd5 || out_timestamp !== 28'h01_00103) begin
         failures++;
         $display("FAIL mask_pass valid=%b ch=%h ts=%h required 1 5 0100103",
                  out_valid, out_channel, out_timestamp);
      end
      do_pop();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL mask_only_one valid=%b required 0", out_valid);
      end
      clear_stats = 1'b1;
      push_word(24'h2_00104);
      clear_stats = 1'b0;
      checks++;
      if (drop_count !== 16'd0 || wrap_seen !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL clear_vs_drop drop=%0d wrap_seen=%b valid=%b required 0 0 0",
                  drop_count, wrap_seen, out_valid);
      end
      ch_mask = 16'hFFFF;
   endtask

   task automatic test_backpressure();
      int idx;
      int n;
      logic v;
      logic acc;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push_word({4'(i), 20'h00200 + 20'(i)});
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL full_flags in_ready=%b valid=%b required 0 1", in_ready, out_valid);
      end
      in_data  = {4'd8, 20'h00208};
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (in_ready !== 1'b0 || out_channel !== 4'd0 || out_timestamp !== 28'h01_00200) begin
            failures++;
            $display("FAIL full_stable cycle=%0d in_ready=%b ch=%h ts=%h required 0 0 0100200",
                     c, in_ready, out_channel, out_timestamp);
         end
      end
      out_ready = 1'b1;
      idx = 0;
      n = 0;
      while (idx < 9 && n < 40) begin
         v   = out_valid;
         acc = in_valid && in_ready;
         if (v) begin
            checks++;
            if (out_channel !== 4'(idx) || out_timestamp !== {8'h01, 20'h00200 + 20'(idx)}) begin
               failures++;
               $display("FAIL bp_order idx=%0d ch=%h ts=%h required %h %h",
                        idx, out_channel, out_timestamp, 4'(idx), {8'h01, 20'h00200 + 20'(idx)});
            end
            $display("bp pop idx=%0d ch=%h ts=%h", idx, out_channel, out_timestamp);
         end
         @(posedge clk); #1;
         if (acc) in_valid = 1'b0;
         if (v) idx++;
         n++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      checks++;
      if (idx != 9 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_count popped=%0d valid=%b required 9 0", idx, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         push_word({4'(k), 20'h00300 + 20'(k)});
      end
      for (int c = 0; c < 20; c++) begin
         in_data   = {4'(c + 4), 20'h00300 + 20'(c + 4)};
         in_valid  = 1'b1;
         out_ready = 1'b1;
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_channel !== 4'(c) ||
             out_timestamp !== {8'h01, 20'h00300 + 20'(c)}) begin
            failures++;
            $display("FAIL concurrent cycle=%0d in_ready=%b valid=%b ch=%h ts=%h required 1 1 %h %h",
                     c, in_ready, out_valid, out_channel, out_timestamp, 4'(c), {8'h01, 20'h00300 + 20'(c)});
         end
         $display("concurrent cycle=%0d ch=%h ts=%h", c, out_channel, out_timestamp);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int c = 20; c < 24; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_channel !== 4'(c) || out_timestamp !== {8'h01, 20'h00300 + 20'(c)}) begin
            failures++;
            $display("FAIL concurrent_drain idx=%0d valid=%b ch=%h ts=%h required 1 %h %h",
                     c, out_valid, out_channel, out_timestamp, 4'(c), {8'h01, 20'h00300 + 20'(c)});
         end
         do_pop();
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL concurrent_empty valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 4; k++) begin
         push_word({4'(k), 20'h00010 + 20'(k)});
      end
      ch_mask = 16'hFFFB;
      push_word(24'h2_00014);
      ch_mask = 16'hFFFF;
      checks++;
      if (out_timestamp !== 28'h02_00010 || wrap_seen !== 1'b1 || drop_count !== 16'd1) begin
         failures++;
         $display("FAIL pre_reset ts=%h wrap_seen=%b drop=%0d required 0200010 1 1",
                  out_timestamp, wrap_seen, drop_count);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset valid=%b in_ready=%b required 0 0", out_valid, in_ready);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || drop_count !== 16'd0 || wrap_seen !== 1'b0) begin
         failures++;
         $display("FAIL resume_state valid=%b drop=%0d wrap_seen=%b required 0 0 0",
                  out_valid, drop_count, wrap_seen);
      end
      push_word(24'h6_00001);
      checks++;
      if (out_valid !== 1'b1 || out_channel !== 4'd6 || out_timestamp !== 28'h00_00001) begin
         failures++;
         $display("FAIL resume_event valid=%b ch=%h ts=%h required 1 6 0000001",
                  out_valid, out_channel, out_timestamp);
      end
      do_pop();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL resume_empty valid=%b required 0", out_valid);
      end
   endtask

   initial begin
      rst         = 1'b1;
      in_data     = '0;
      in_valid    = 1'b0;
      ch_mask     = 16'hFFFF;
      clear_stats = 1'b0;
      out_ready   = 1'b0;
      test_reset();
      test_single();
      test_wrap();
      test_mask();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aer_event_decoder.md
Name: aer_event_decoder

Overview:
Parametrised successor to the AER input decoder for the neural accelerator. It accepts packed AER words {channel, timestamp} under a valid/ready handshake and drops events from masked channels. It extends the raw timestamp with a wrap counter and buffers events in a small FIFO. It presents decoded events to the downstream spike-processing core under a valid/ready handshake and counts dropped events.

Parameters:
CH_W, 4, channel-id width; the block supports 2**CH_W channels
TS_W, 20, raw timestamp width carried in the AER word
EXT_W, 8, wrap-extension bits prepended to the timestamp
DEPTH, 8, FIFO depth in events; power of two, at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_data  in  CH_W+TS_W  AER word: [CH_W+TS_W-1:TS_W]=channel, [TS_W-1:0]=raw timestamp
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word
ch_mask  in  2**CH_W  bit i=1 enables channel i; quasi-static
clear_stats  in  1  one-cycle pulse that clears drop_count and wrap_seen
out_valid  out  1  decoded event available
out_ready  in  1  downstream accepts the event
out_channel  out  CH_W  channel id of the head event
out_timestamp  out  EXT_W+TS_W  {wrap_cnt, raw timestamp} of the head event
drop_count  out  16  number of masked-channel events discarded; saturating
wrap_seen  out  1  sticky flag, set on the first timestamp wrap

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset clears the FIFO pointers, last_ts, wrap_cnt, drop_count and wrap_seen.
  - While rst=1: out_valid=0, out_channel=0, out_timestamp=0 and in_ready=0.
  - On the first cycle after rst falls, in_ready=1.
  - A reset asserted mid-stream discards all buffered events; no partial event is emitted.
- Accept rule: an input word is accepted when in_valid && in_ready. in_ready = !fifo_full.
  - There is no pass-through when full: a pop in the same cycle does not raise in_ready.
- Wrap tracking runs on every accepted word, masked or not:
  - If raw_ts < last_ts, then wrap_cnt <= wrap_cnt+1 and wrap_seen <= 1.
  - raw_ts == last_ts is not a wrap.
  - last_ts <= raw_ts on every accepted word.
  - wrap_cnt wraps modulo 2**EXT_W.
  - The extended timestamp uses the post-increment wrap_cnt value.
- Masking: an accepted word with ch_mask[channel]=0 is discarded and drop_count increments.
  - drop_count saturates at 16'hFFFF.
  - An accepted word with ch_mask[channel]=1 is pushed into the FIFO as {channel, wrap_cnt, raw_ts}.
- Latency: an unmasked word accepted at edge N into an empty FIFO gives out_valid=1 in the cycle after edge N (one-cycle latency).
- Output handshake: the FIFO is show-ahead, with the head driven on out_channel and out_timestamp.
  - The head is popped on out_valid && out_ready.
  - out_channel and out_timestamp hold stable while out_valid && !out_ready.
  - out_valid never drops without a pop.
  - Outputs read 0 when the FIFO is empty.
- Simultaneous push and pop while the FIFO is non-empty and not full: both occur and the occupancy is unchanged.
- Full: in_ready=0. Upstream holds its word, and the block loses no data.
- Empty: out_valid=0. An out_ready on an empty FIFO is ignored.
- clear_stats:
  - It clears drop_count and wrap_seen.
  - If it coincides with a drop, the result is drop_count=0 (clear wins).
  - It does not affect wrap_cnt, last_ts or the FIFO.
- Occupancy counter width is log2(DEPTH)+1. The pointers wrap naturally.

Decomposition:
- Package aer_pkg: the default CH_W/TS_W/EXT_W constants, the AER word field-slice localparams, and an event typedef {channel, ext_timestamp}.
- Sub-module aer_sync_fifo (parameters WIDTH, DEPTH): single-clock, show-ahead, full/empty outputs, synchronous active-high reset.
- Masking, wrap tracking and statistics stay in the top module.

Test Plan:
- Reset then a single event: push 24'h3_00010 with all channels enabled. Expected next cycle: out_valid=1, out_channel=3, out_timestamp=28'h00_00010.
- Wrap: push ts 20'hFFFF0, then 20'h00005. Expected second event out_timestamp=28'h01_00005 and wrap_seen=1. An equal timestamp does not increment the wrap count.
- Mask: ch_mask=16'hFFFB, push 3 events on channel 2 and 1 on channel 5. Expected: only the channel-5 event is emitted and drop_count=3. A clear_stats pulse together with a channel-2 push gives drop_count=0.
- Backpressure: out_ready=0, push 8 events (DEPTH=8). Expected: in_ready=0 after the 8th, the 9th is held upstream, outputs are stable. Release out_ready: all 9 emerge in order.
- Concurrent push and pop at half occupancy for 20 cycles. Expected: constant occupancy, order preserved, no loss.
- Mid-stream reset with 4 events buffered. Expected: out_valid=0 the cycle after rst=1, and drop_count=0 and wrap_cnt=0 on resume.
